game_flow_ctrl: RTL and testbench

Top-level game sequencer. Owns the 2-bit screen `state` and the `blink_signal` consumed by the menu/game-over renderer, in the encoding MENU=0, PLAY=1, END=2. Derives frame timing from `v_sync` and debounces the fire button at frame rate. Tracks lives and wave level, and issues the start pulse that re-initialises the play-field datapath.

---
 rtl/game_pkg.sv | 13 +
 rtl/btn_debounce.sv | 58 +++++
 rtl/game_flow_ctrl.sv | 178 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared screen-state encoding and wave limit for the game sequencer,
// the renderer and the play-field logic.
package game_pkg;

  typedef enum logic [1:0] {
    ST_MENU = 2'd0,
    ST_PLAY = 2'd1,
    ST_END  = 2'd2
  } game_state_t;

  localparam logic [3:0] MAX_LEVEL = 4'd15;

endpackage

// File: rtl/btn_debounce.sv
// Fire-button conditioner: two-flop synchroniser, then a frame-rate debounce
// that needs DEBOUNCE_FRAMES consecutive differing samples before it flips.
module btn_debounce #(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

  logic             r_btnMeta;
  logic             r_btnSync;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_stableCnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_differs;
  logic             w_flip;

  assign w_cntNext = r_stableCnt + 1'b1;
  assign w_differs = (r_btnSync != r_level);
  assign w_flip    = frame_tick && w_differs && (w_cntNext == CNT_W'(DEBOUNCE_FRAMES));

  // The press pulse is registered on the same edge the level rises, so the
  // two are always seen together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_btnMeta   <= 1'b0;
      r_btnSync   <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_stableCnt <= '0;
    end else begin
      r_btnMeta <= btn_raw;
      r_btnSync <= r_btnMeta;
      r_press   <= w_flip && !r_level;
      if (frame_tick) begin
        if (w_flip) begin
          r_level     <= ~r_level;
          r_stableCnt <= '0;
        end else if (w_differs) begin
          r_stableCnt <= w_cntNext;
        end else begin
          r_stableCnt <= '0;
        end
      end
    end
  end

  assign btn_level = r_level;
  assign btn_press = r_press;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: frame timing from v_sync, MENU/PLAY/END flow,
// fire lockout, prompt blink, idle timeout, lives and wave tracking.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES           = 3,
  parameter int BLINK_FRAMES    = 30,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int LOCKOUT_FRAMES  = 60,
  parameter int IDLE_FRAMES     = 900
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       v_sync,
  input  logic       btn_fire,
  input  logic       player_hit,
  input  logic       aliens_cleared,
  output logic [1:0] state,
  output logic       blink_signal,
  output logic       frame_tick,
  output logic       game_start,
  output logic       wave_start,
  output logic [1:0] lives,
  output logic [3:0] level
);

  localparam int LOCK_W  = $clog2(LOCKOUT_FRAMES + 1);
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam int IDLE_W  = $clog2(IDLE_FRAMES + 1);

  logic [3:0]         r_vsPipe;
  logic               r_frameTick;
  logic               r_hitPrev;
  logic               r_clearPrev;
  logic [1:0]         r_state;
  logic [LOCK_W-1:0]  r_lockout;
  logic [BLINK_W-1:0] r_blinkCnt;
  logic               r_blinkPhase;
  logic [IDLE_W-1:0]  r_idleCnt;
  logic [1:0]         r_lives;
  logic [3:0]         r_level;
  logic               r_gameStart;
  logic               r_waveStart;

  logic       w_btnLevel;
  logic       w_btnPress;
  logic       w_hitEdge;
  logic       w_clearEdge;
  logic       w_lockClear;
  logic       w_fireAccept;
  logic       w_idleDone;
  logic       w_gameOver;
  logic       w_startGame;
  logic       w_stateChange;
  logic       w_enterLockout;
  logic [1:0] w_nextState;

  btn_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_btnDebounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(r_frameTick),
    .btn_raw   (btn_fire),
    .btn_level (w_btnLevel),
    .btn_press (w_btnPress)
  );

  always_comb begin
    w_hitEdge    = player_hit && !r_hitPrev;
    w_clearEdge  = aliens_cleared && !r_clearPrev;
    w_lockClear  = (r_lockout == '0);
    w_fireAccept = w_btnPress && w_btnLevel && w_lockClear;
    w_idleDone   = r_frameTick && (r_idleCnt == IDLE_W'(IDLE_FRAMES - 1));
    w_gameOver   = (r_state == ST_PLAY) && w_hitEdge && (r_lives == 2'd1);
    w_nextState  = r_state;
    w_startGame  = 1'b0;
    case (r_state)
      ST_MENU: begin
        if (w_fireAccept) begin
          w_nextState = ST_PLAY;
          w_startGame = 1'b1;
        end
      end
      ST_PLAY: begin
        if (w_gameOver) w_nextState = ST_END;
      end
      ST_END: begin
        if (w_fireAccept) begin
          w_nextState = ST_PLAY;
          w_startGame = 1'b1;
        end else if (w_idleDone) begin
          w_nextState = ST_MENU;
        end
      end
      default: w_nextState = ST_MENU;
    endcase
    w_stateChange  = (w_nextState != r_state);
    w_enterLockout = w_stateChange && (w_nextState != ST_PLAY);
  end

  // Sync plus one alignment stage puts the tick three edges after v_sync is first seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vsPipe    <= '0;
      r_frameTick <= 1'b0;
      r_hitPrev   <= 1'b0;
      r_clearPrev <= 1'b0;
    end else begin
      r_vsPipe    <= {r_vsPipe[2:0], v_sync};
      r_frameTick <= r_vsPipe[2] && !r_vsPipe[3];
      r_hitPrev   <= player_hit;
      r_clearPrev <= aliens_cleared;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_MENU;
      r_gameStart  <= 1'b0;
      r_lockout    <= LOCK_W'(LOCKOUT_FRAMES);
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
      r_idleCnt    <= '0;
    end else begin
      r_state     <= w_nextState;
      r_gameStart <= w_startGame;

      if (w_enterLockout) r_lockout <= LOCK_W'(LOCKOUT_FRAMES);
      else if (r_frameTick && !w_lockClear) r_lockout <= r_lockout - 1'b1;

      if (w_stateChange) begin
        r_blinkCnt   <= '0;
        r_blinkPhase <= 1'b1;
      end else if (r_frameTick) begin
        if (r_blinkCnt == BLINK_W'(BLINK_FRAMES - 1)) begin
          r_blinkCnt   <= '0;
          r_blinkPhase <= ~r_blinkPhase;
        end else begin
          r_blinkCnt <= r_blinkCnt + 1'b1;
        end
      end

      if (w_stateChange) r_idleCnt <= '0;
      else if (r_state == ST_END && r_frameTick) r_idleCnt <= r_idleCnt + 1'b1;
    end
  end

  // A game-ending hit swallows a wave clear arriving on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lives     <= 2'd0;
      r_level     <= 4'd0;
      r_waveStart <= 1'b0;
    end else begin
      r_waveStart <= 1'b0;
      if (w_startGame) begin
        r_lives <= 2'(LIVES);
        r_level <= 4'd1;
      end else if (r_state == ST_PLAY) begin
        if (w_hitEdge && r_lives != 2'd0) r_lives <= r_lives - 2'd1;
        if (w_clearEdge && !w_gameOver) begin
          r_level     <= (r_level == MAX_LEVEL) ? MAX_LEVEL : r_level + 4'd1;
          r_waveStart <= 1'b1;
        end
      end
    end
  end

  assign state        = r_state;
  assign blink_signal = r_blinkPhase && w_lockClear;
  assign frame_tick   = r_frameTick;
  assign game_start   = r_gameStart;
  assign wave_start   = r_waveStart;
  assign lives        = r_lives;
  assign level        = r_level;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios plus random
// button/hit/clear traffic compared against a frame-level behavioural model.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int P_LIVES = 3;
  localparam int P_BLINK = 2;
  localparam int P_DEB   = 2;
  localparam int P_LOCK  = 3;
  localparam int P_IDLE  = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v_sync = 1'b0;
  logic       btn_fire = 1'b0;
  logic       player_hit = 1'b0;
  logic       aliens_cleared = 1'b0;
  logic [1:0] state;
  logic       blink_signal;
  logic       frame_tick;
  logic       game_start;
  logic       wave_start;
  logic [1:0] lives;
  logic [3:0] level;

  game_flow_ctrl #(
    .LIVES(P_LIVES), .BLINK_FRAMES(P_BLINK), .DEBOUNCE_FRAMES(P_DEB),
    .LOCKOUT_FRAMES(P_LOCK), .IDLE_FRAMES(P_IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .v_sync(v_sync), .btn_fire(btn_fire),
    .player_hit(player_hit), .aliens_cleared(aliens_cleared),
    .state(state), .blink_signal(blink_signal), .frame_tick(frame_tick),
    .game_start(game_start), .wave_start(wave_start), .lives(lives), .level(level)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // Behavioural model: game facts plus frame counts since the relevant events.
  int mState, mLives, mLevel;
  int mSinceLock, mSinceEntry, mPhase0, mIdle;
  int mDebLevel, mPrevH, mPrevC;
  int mHist[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed == expected) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int lockoutExp();
    return (mSinceLock >= P_LOCK) ? 0 : P_LOCK - mSinceLock;
  endfunction

  function automatic int blinkExp();
    return ((((mPhase0 + mSinceEntry / P_BLINK) % 2) == 1) && lockoutExp() == 0) ? 1 : 0;
  endfunction

  task automatic enterState(input int s);
    mState      = s;
    mSinceEntry = 0;
    mPhase0     = 1;
    mIdle       = 0;
    if (s != int'(ST_PLAY)) mSinceLock = 0;
  endtask

  task automatic modelReset();
    mState = int'(ST_MENU); mLives = 0; mLevel = 0;
    mSinceLock = 0; mSinceEntry = 0; mPhase0 = 0; mIdle = 0;
    mDebLevel = 0; mPrevH = 0; mPrevC = 0;
    mHist.delete();
  endtask

  task automatic checkAll(input string where);
    checkOutput({where, ".state"}, int'(state), mState);
    checkOutput({where, ".lives"}, int'(lives), mLives);
    checkOutput({where, ".level"}, int'(level), mLevel);
    checkOutput({where, ".blink"}, int'(blink_signal), blinkExp());
  endtask

  // One frame boundary as seen by the model; returns 1 on a debounced press.
  task automatic modelTick(input int b, output int rise);
    bit entered;
    bit allDiff;
    entered = 1'b0;
    if (mState == int'(ST_END)) begin
      mIdle++;
      if (mIdle == P_IDLE) begin
        enterState(int'(ST_MENU));
        entered = 1'b1;
      end
    end
    if (!entered) begin
      mSinceLock++;
      mSinceEntry++;
    end
    mHist.push_back(b);
    if (mHist.size() > P_DEB) void'(mHist.pop_front());
    rise = 0;
    if (mHist.size() == P_DEB) begin
      allDiff = 1'b1;
      foreach (mHist[i]) if (mHist[i] == mDebLevel) allDiff = 1'b0;
      if (allDiff) begin
        mDebLevel = 1 - mDebLevel;
        mHist.delete();
        rise = mDebLevel;
      end
    end
  endtask

  task automatic doReset(input int b);
    rst_n = 1'b0; btn_fire = (b != 0); player_hit = 1'b0; aliens_cleared = 1'b0; v_sync = 1'b0;
    step();
    modelReset();
    checkOutput("rst.state", int'(state), 0);
    checkOutput("rst.lives", int'(lives), 0);
    checkOutput("rst.level", int'(level), 0);
    checkOutput("rst.blink", int'(blink_signal), 0);
    checkOutput("rst.tick", int'(frame_tick), 0);
    checkOutput("rst.gameStart", int'(game_start), 0);
    checkOutput("rst.waveStart", int'(wave_start), 0);
    step();
    rst_n = 1'b1;
  endtask

  // One video frame with the fire button held at b throughout.
  task automatic applyStimulus(input int b);
    int rise;
    int expStart;
    btn_fire = (b != 0);
    repeat (4) step();
    v_sync = 1'b1;
    step(); step(); step();
    checkOutput("tickEarly", int'(frame_tick), 0);
    step();
    checkOutput("tickRise", int'(frame_tick), 1);
    v_sync = 1'b0;
    step();
    checkOutput("tickWidth", int'(frame_tick), 0);
    modelTick(b, rise);
    expStart = 0;
    if (rise == 1 && mState != int'(ST_PLAY) && lockoutExp() == 0) begin
      enterState(int'(ST_PLAY));
      mLives = P_LIVES;
      mLevel = 1;
      expStart = 1;
    end
    step();
    checkOutput("gameStart", int'(game_start), expStart);
    step();
    checkOutput("gameStartWidth", int'(game_start), 0);
    checkAll("frame");
    repeat (3) step();
  endtask

  task automatic setLevels(input int h, input int c);
    int hitE, clrE, expWave;
    player_hit = (h != 0);
    aliens_cleared = (c != 0);
    hitE = (h != 0 && mPrevH == 0) ? 1 : 0;
    clrE = (c != 0 && mPrevC == 0) ? 1 : 0;
    mPrevH = (h != 0) ? 1 : 0;
    mPrevC = (c != 0) ? 1 : 0;
    expWave = 0;
    if (mState == int'(ST_PLAY)) begin
      if (hitE == 1) begin
        if (mLives == 1) begin
          mLives = 0;
          enterState(int'(ST_END));
        end else begin
          mLives--;
        end
      end
      if (clrE == 1 && mState == int'(ST_PLAY)) begin
        mLevel = (mLevel >= 15) ? 15 : mLevel + 1;
        expWave = 1;
      end
    end
    step();
    checkOutput("waveStart", int'(wave_start), expWave);
    checkAll("levels");
  endtask

  initial begin
    int r;
    @(negedge clk);
    doReset(0);

    // Early press is swallowed by the lockout; second press starts the game.
    applyStimulus(1); applyStimulus(1); applyStimulus(1); applyStimulus(1);
    applyStimulus(0); applyStimulus(0);
    applyStimulus(1); applyStimulus(1);
    applyStimulus(0); applyStimulus(0);

    // Hit, then hit+clear twice: the second pair ends the game.
    setLevels(1, 0); setLevels(0, 0);
    setLevels(1, 1); setLevels(0, 0);
    setLevels(1, 1); setLevels(0, 0);

    // Idle timeout back to MENU.
    for (int i = 0; i < P_IDLE; i++) applyStimulus(0);

    // Restart from MENU, lose, restart from END on frame 4 with a clear held high.
    applyStimulus(0); applyStimulus(0); applyStimulus(0);
    applyStimulus(1); applyStimulus(1);
    for (int i = 0; i < P_LIVES; i++) begin
      setLevels(1, 0);
      setLevels(0, 0);
    end
    setLevels(0, 1);
    applyStimulus(0); applyStimulus(0); applyStimulus(1); applyStimulus(1);
    setLevels(0, 1);
    setLevels(0, 0);
    for (int i = 0; i < 15; i++) begin
      setLevels(0, 1);
      setLevels(0, 0);
    end
    applyStimulus(0); applyStimulus(0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(int'($urandom_range(0, 1)));
      if (mState == int'(ST_PLAY)) begin
        r = int'($urandom_range(0, 3));
        setLevels(r & 1, (r >> 1) & 1);
        setLevels(0, 0);
      end
    end

    // Button held through reset never starts a game.
    doReset(1);
    for (int i = 0; i < 8; i++) applyStimulus(1);
    applyStimulus(0); applyStimulus(0);
    applyStimulus(1); applyStimulus(1);
    setLevels(1, 0); setLevels(0, 0);

    // Reset in the middle of PLAY.
    doReset(0);
    applyStimulus(0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
